// File: rtl/vt52_pkg.sv
// Shared types and constants for the VT52 mode sequencer.
package vt52_pkg;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_SETTLE,
        ST_IDLE,
        ST_WAIT_VB,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic pal;
        logic scandouble;
    } mode_t;

    // Bit positions in the edge-detector vector
    localparam int unsigned EDGE_VBLANK = 0;
    localparam int unsigned EDGE_VSYNC  = 1;
    localparam int unsigned EDGE_HSYNC  = 2;

    // Nominal lines per frame (single / scandoubled)
    localparam logic [9:0] LINES_NTSC    = 10'd262;
    localparam logic [9:0] LINES_NTSC_SD = 10'd524;
    localparam logic [9:0] LINES_PAL     = 10'd312;
    localparam logic [9:0] LINES_PAL_SD  = 10'd624;

    function automatic logic [9:0] nominal_lines(input mode_t m);
        logic [9:0] v;
        case ({m.pal, m.scandouble})
            2'b00:   v = LINES_NTSC;
            2'b01:   v = LINES_NTSC_SD;
            2'b10:   v = LINES_PAL;
            default: v = LINES_PAL_SD;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vt52_mode_sequencer_if.sv
// Mode-request handshake between the OSD/config side and the sequencer.
interface vt52_mode_sequencer_if;

    logic cfg_valid;
    logic cfg_ready;
    logic cfg_pal;
    logic cfg_scandouble;
    logic cfg_done;

    modport master (
        output cfg_valid,
        output cfg_pal,
        output cfg_scandouble,
        input  cfg_ready,
        input  cfg_done
    );

    modport slave (
        input  cfg_valid,
        input  cfg_pal,
        input  cfg_scandouble,
        output cfg_ready,
        output cfg_done
    );

endinterface

// File: rtl/vt52_edge_det.sv
// Registered rising-edge detector for vblank/vsync/hsync.
module vt52_edge_det (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] i_sig,
    output logic [2:0] o_rise
);

    logic [2:0] r_prev;

    // Previous-sample registers, cleared on reset
    always_ff @(posedge clk) begin
        if (reset) r_prev <= '0;
        else       r_prev <= i_sig;
    end

    assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/vt52_mode_sequencer.sv
// VT52 mode sequencer: applies pal/scandouble changes at vblank, then
// holds the timing generator in reset and mutes video until it settles.
// Optional line measurement enabled by defining VT52_LINE_MEASURE_EN.
module vt52_mode_sequencer
    import vt52_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned SETTLE_FRAMES = 2,
    parameter int unsigned VB_TIMEOUT    = 2000000,
    parameter logic        PAL_DEFAULT   = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    vt52_mode_sequencer_if.slave  cfg,
    input  logic                  vblank,
    input  logic                  vsync,
    input  logic                  hsync,
    output logic                  pal,
    output logic                  scandouble,
    output logic                  gen_reset,
    output logic                  video_mute,
    output logic [9:0]            lines_per_frame
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > VB_TIMEOUT) ? HOLD_CYCLES : VB_TIMEOUT;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_FRAMES - 1);
    localparam logic [CNT_W-1:0] VB_LAST     = CNT_W'(VB_TIMEOUT - 1);

    logic [2:0]       w_rise;
    logic             w_vblank_rise;
    logic             w_vsync_rise;
    logic             w_hsync_rise;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    mode_t            r_mode;
    mode_t            r_pend;
    mode_t            w_req;
    logic             w_accept;
    logic             w_apply;

    logic             r_gen_reset;
    logic             r_video_mute;
    logic             r_cfg_ready;
    logic             r_cfg_done;

    vt52_edge_det u_edge_det (
        .clk    (clk),
        .reset  (reset),
        .i_sig  ({hsync, vsync, vblank}),
        .o_rise (w_rise)
    );

    assign w_vblank_rise  = w_rise[EDGE_VBLANK];
    assign w_vsync_rise   = w_rise[EDGE_VSYNC];
    assign w_hsync_rise   = w_rise[EDGE_HSYNC];
    assign w_req.pal        = cfg.cfg_pal;
    assign w_req.scandouble = cfg.cfg_scandouble;

    // State and counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter and transfer/apply decisions
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_apply     = 1'b0;
        case (r_state)
            ST_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (w_vsync_rise) begin
                    if (r_cnt == SETTLE_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (cfg.cfg_valid && r_cfg_ready) begin
                    w_accept = 1'b1;
                    if (w_req == r_mode) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_WAIT_VB;
                    end
                end
            end
            ST_WAIT_VB: begin
                // A vblank rise coinciding with timeout is one transition
                if (w_vblank_rise || (r_cnt == VB_LAST)) begin
                    w_apply     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_HOLD;
            end
        endcase
    end

    // Registered outputs follow the next state so they align with r_state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode.pal        <= PAL_DEFAULT;
            r_mode.scandouble <= 1'b0;
            r_pend            <= '0;
            r_gen_reset       <= 1'b1;
            r_video_mute      <= 1'b1;
            r_cfg_ready       <= 1'b0;
            r_cfg_done        <= 1'b0;
        end else begin
            if (w_accept) r_pend <= w_req;
            if (w_apply)  r_mode <= r_pend;
            r_gen_reset  <= (w_state_nxt == ST_HOLD);
            r_video_mute <= (w_state_nxt == ST_HOLD) || (w_state_nxt == ST_SETTLE);
            r_cfg_ready  <= (w_state_nxt == ST_IDLE);
            r_cfg_done   <= (w_state_nxt == ST_DONE);
        end
    end

    assign pal           = r_mode.pal;
    assign scandouble    = r_mode.scandouble;
    assign gen_reset     = r_gen_reset;
    assign video_mute    = r_video_mute;
    assign cfg.cfg_ready = r_cfg_ready;
    assign cfg.cfg_done  = r_cfg_done;

`ifdef VT52_LINE_MEASURE_EN
    logic [9:0] r_lines;
    logic [9:0] r_lines_per_frame;

    // Saturating line counter, captured and cleared on each vsync rise
    always_ff @(posedge clk) begin
        if (reset || r_gen_reset) begin
            r_lines           <= '0;
            r_lines_per_frame <= '0;
        end else if (w_vsync_rise) begin
            r_lines_per_frame <= r_lines;
            r_lines           <= '0;
        end else if (w_hsync_rise && (r_lines != '1)) begin
            r_lines <= r_lines + 1'b1;
        end
    end

    assign lines_per_frame = r_lines_per_frame;
`else
    logic w_unused_hsync_rise;
    assign w_unused_hsync_rise = w_hsync_rise;
    assign lines_per_frame     = '0;
`endif

endmodule

// File: doc/vt52_mode_sequencer.md
Name: vt52_mode_sequencer

Overview:
Controller that owns the VT52 timing generator's `pal`/`scandouble` mode inputs and its reset.
- Accepts mode-change requests from the OSD/config side over a valid/ready handshake.
- Defers each change to the next vertical-blank boundary.
- Holds the generator in reset for a fixed window, then mutes video until the new timing has produced a set number of full frames.
- Sits between the config menu logic and the timing/pattern generator, in the generator's clock domain.

Parameters:
- HOLD_CYCLES, 16: clocks `gen_reset` stays asserted per mode switch (min 1).
- SETTLE_FRAMES, 2: VSync rising edges to wait after release before unmuting (min 1).
- VB_TIMEOUT, 2000000: max clocks to wait for VBlank rise before forcing the switch.
- PAL_DEFAULT, 0: `pal` value after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cfg_valid  in  1  mode request valid
- cfg_ready  out  1  sequencer can accept request
- cfg_pal  in  1  requested PAL mode
- cfg_scandouble  in  1  requested scandouble mode
- vblank  in  1  VBlank from timing generator
- vsync  in  1  VSync from timing generator
- hsync  in  1  HSync from timing generator
- pal  out  1  applied PAL mode to generator
- scandouble  out  1  applied scandouble mode to generator
- gen_reset  out  1  reset to timing generator
- video_mute  out  1  forces video to black downstream
- cfg_done  out  1  one-cycle pulse when a request completes
- lines_per_frame  out  10  measured lines per frame (optional feature only)

Behaviour:
- Clock and reset: one clock `clk`; reset `reset` is synchronous, active-high.
- Edge detect:
  - `vblank`, `vsync`, `hsync` are each registered once (prev regs).
  - Rise = cur & ~prev.
  - Prev regs clear to 0 on reset.
- States: HOLD, SETTLE, IDLE, WAIT_VB, DONE.
- Reset values:
  - state = HOLD, counter = 0.
  - pal = PAL_DEFAULT, scandouble = 0.
  - gen_reset = 1, video_mute = 1, cfg_ready = 0, cfg_done = 0.
- HOLD:
  - gen_reset = 1, video_mute = 1.
  - Counter increments each clock.
  - At count HOLD_CYCLES-1: clear counter, go to SETTLE.
- SETTLE:
  - gen_reset = 0, video_mute = 1.
  - Counter counts vsync rises.
  - At SETTLE_FRAMES rises, go to DONE.
- DONE:
  - One cycle, cfg_done = 1, then IDLE.
  - Post-reset pass through DONE also pulses cfg_done.
- IDLE:
  - cfg_ready = 1, video_mute = 0, gen_reset = 0.
  - Transfer on cfg_valid & cfg_ready. Requested bits latch into pending regs.
  - Pending == applied {pal, scandouble}: go to DONE directly; no reset, no mute.
  - Otherwise: go to WAIT_VB with counter cleared.
- WAIT_VB:
  - cfg_ready = 0, video_mute = 0.
  - On vblank rise, or counter reaching VB_TIMEOUT-1: apply pending to pal/scandouble, clear counter, go to HOLD.
  - `pal`/`scandouble` change only on this transition.
- Outputs `pal`, `scandouble`, `gen_reset`, `video_mute`, `cfg_ready`, `cfg_done` are registered; `cfg_ready` reflects current state.
- cfg_valid while not ready is ignored (not queued). The requester holds it.
- Reset mid-operation: discards pending request, returns to reset values, re-runs HOLD→SETTLE→DONE with PAL_DEFAULT mode.
- vblank rise in the same cycle as timeout: a single transition, no double count.
- Counter width: ceil(log2(max(HOLD_CYCLES, VB_TIMEOUT))) bits. No wrap in any state.

Optional Feature:
- Macro: VT52_LINE_MEASURE_EN.
- Defined:
  - 10-bit line counter increments on hsync rise and clears on vsync rise.
  - On each vsync rise, the pre-clear count is captured into lines_per_frame.
  - Counter saturates at 1023.
  - Counter and register clear on reset and while gen_reset = 1.
- Undefined: lines_per_frame tied to 0, no counter logic.

Decomposition:
- Shared package `vt52_pkg`:
  - state enum.
  - Mode struct {pal, scandouble}.
  - Constants for nominal lines per frame: NTSC 262/524, PAL 312/624 (single/scandouble).
- One natural sub-module: `vt52_edge_det`, a 3-bit registered rising-edge detector for vblank/vsync/hsync.

Test Plan (HOLD_CYCLES=4, SETTLE_FRAMES=1, VB_TIMEOUT=100):
- Reset 3 cycles then release → gen_reset high exactly 4 cycles, mute until first vsync rise, cfg_done pulse, cfg_ready=1, pal=0.
- Request {1,0} in IDLE, vblank rises 20 cycles later → pal switches to 1 on the vblank-rise transition, gen_reset high 4 cycles, cfg_done after next vsync rise.
- Request equal to current mode → cfg_done the cycle after DONE entry; gen_reset and mute never assert.
- Request with vblank held low → switch forced after 100 cycles in WAIT_VB; rest of sequence as normal.
- Reset asserted during SETTLE of a pending PAL switch → pal returns to 0, HOLD re-runs, no stray cfg_done before the new DONE.
- With VT52_LINE_MEASURE_EN: drive 262 hsync pulses between vsync rises → lines_per_frame = 262; 1100 pulses → 1023.
